// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, valid/ready memory port, lane steering and load extension.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip memory and complete with resp_misaligned.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_error,
    output logic                 resp_misaligned,
    output logic                 busy,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_wstrb,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic [1:0]           state_dbg
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // the valid side holds its payload stable until then and never waits on ready to assert valid.
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("load_store_unit: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t state, next_state;

    logic              store_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     strb_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic [1:0]        req_size;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  req_off;
    logic [NB-1:0]     req_strb;
    logic              legal;
    logic              timeout_hit;
`ifdef MISALIGN_TRAP_EN
    logic              misaligned;
    logic              mis_q;
`endif

    always_comb begin
        req_size  = req_funct3[1:0];
        size_mask = OFF_W'((32'd1 << req_size) - 32'd1);
`ifdef MISALIGN_TRAP_EN
        misaligned = |(req_addr[OFF_W-1:0] & size_mask);
        req_off    = req_addr[OFF_W-1:0];
`else
        // Without the trap the lane is rounded down to the access size.
        req_off = req_addr[OFF_W-1:0] & ~size_mask;
`endif
        req_strb = NB'((32'd1 << (32'd1 << req_size)) - 32'd1) << req_off;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:                 legal = (XLEN == 64);
            3'b100, 3'b101:         legal = !req_store;
            3'b110:                 legal = !req_store && (XLEN == 64);
            default:                legal = 1'b0;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!legal) next_state = DONE;
`ifdef MISALIGN_TRAP_EN
                    else if (misaligned) next_state = DONE;
`endif
                    else next_state = REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                if (mem_ready || timeout_hit) next_state = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Load path: bring the addressed lane to bit 0, then sign/zero extend from the access size.
    logic [XLEN-1:0] load_shifted, load_left, load_sext, load_ext;
    logic [6:0]      ext_sh;

    always_comb begin
        load_shifted = mem_rdata >> {off_q, 3'b000};
        ext_sh       = 7'(XLEN) - (7'd8 << funct3_q[1:0]);
        load_left    = load_shifted << ext_sh;
        load_sext    = $signed(load_left) >>> ext_sh;
        load_ext     = funct3_q[2] ? (load_left >> ext_sh) : load_sext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_q  <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            strb_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    store_q  <= req_store;
                    funct3_q <= req_funct3;
                    off_q    <= req_off;
                    addr_q   <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    strb_q   <= req_store ? req_strb : '0;
                    wdata_q  <= req_store ? (req_wdata << {req_off, 3'b000}) : '0;
                    wait_cnt <= '0;
                    err_q    <= !legal;
`ifdef MISALIGN_TRAP_EN
                    mis_q    <= legal && misaligned;
`endif
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!store_q) rdata_q <= load_ext;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = !req_ready;
    assign mem_we     = mem_valid & store_q;
    assign mem_addr   = mem_valid ? addr_q  : '0;
    assign mem_wstrb  = mem_valid ? strb_q  : '0;
    assign mem_wdata  = mem_valid ? wdata_q : '0;
    assign resp_rdata = rdata_q;
    assign resp_error = resp_valid & err_q;
    assign state_dbg  = state;
`ifdef MISALIGN_TRAP_EN
    assign resp_misaligned = resp_valid & mis_q;
`else
    assign resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT=4); memory always returns 0xdeadbeef.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error, resp_misaligned, busy;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cur_delay = 0;
    int tb_wait = 0;

    logic [33:0] exp_q[$];
    logic [68:0] mem_exp_q[$];

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .resp_misaligned(resp_misaligned), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;
    assign mem_rdata = 32'hdeadbeef;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void exp_resp(input logic err, input logic mis, input logic [31:0] rdata);
        exp_q.push_back({err, mis, rdata});
    endfunction

    function automatic void exp_mem(input logic we, input logic [3:0] strb,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        mem_exp_q.push_back({we, strb, addr, wdata});
    endfunction

    // Memory responder: holds mem_ready low for cur_delay cycles of each request
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_valid) begin
                if (tb_wait >= cur_delay) mem_ready = 1'b1;
                else begin
                    mem_ready = 1'b0;
                    tb_wait++;
                end
            end else begin
                mem_ready = 1'b0;
                tb_wait = 0;
            end
        end
    end

    // Scoreboard monitors
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %0h err %0b, none expected", resp_rdata, resp_error);
                end else begin
                    check("resp", {35'd0, resp_error, resp_misaligned, resp_rdata}, {35'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (mem_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem: got addr %0h we %0b, none expected", mem_addr, mem_we);
                end else begin
                    check("mem_req", {mem_we, mem_wstrb, mem_addr, mem_wdata}, mem_exp_q[0]);
                    if (mem_ready) void'(mem_exp_q.pop_front());
                end
            end
        end
    end

    // Driver: issue one request from IDLE and measure cycles from accept to resp_valid
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input int exp_lat);
        int lat;
        cur_delay  = delay;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            // a request raised while busy must be dropped
            if (delay > 0 && delay < 50 && lat == 2) begin
                req_valid = 1'b1;
                req_addr  = 32'h10;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        check("latency", 69'(lat), 69'(exp_lat));
        @(posedge clk); #1;
        check("ready_after_resp", {68'd0, req_ready}, 69'd1);
        if (delay >= 50) mem_exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_req_ready", {68'd0, req_ready}, 69'd1);
        check("reset_busy", {68'd0, busy}, 69'd0);
        check("reset_outputs", {59'd0, resp_valid, resp_error, mem_valid, mem_we, mem_wstrb, state_dbg}, 69'd0);
        check("reset_rdata", {37'd0, resp_rdata}, 69'd0);

        // Loads, zero wait states
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hdeadbeef);
        issue(0, 3'b010, 32'ha8, 32'h0, 0, 2);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hffffffde);
        issue(0, 3'b000, 32'hab, 32'h0, 0, 2);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'h000000de);
        issue(0, 3'b100, 32'hab, 32'h0, 0, 2);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hffffdead);
        issue(0, 3'b001, 32'haa, 32'h0, 0, 2);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'h0000beef);
        issue(0, 3'b101, 32'ha8, 32'h0, 0, 2);

        // Stores leave resp_rdata at the last load value
        exp_mem(1, 4'b0010, 32'ha8, 32'h00005500); exp_resp(0, 0, 32'h0000beef);
        issue(1, 3'b000, 32'ha9, 32'h55, 0, 2);
        exp_mem(1, 4'b1100, 32'ha8, 32'h12340000); exp_resp(0, 0, 32'h0000beef);
        issue(1, 3'b001, 32'haa, 32'h1234, 0, 2);
        exp_mem(1, 4'b1111, 32'hac, 32'hcafef00d); exp_resp(0, 0, 32'h0000beef);
        issue(1, 3'b010, 32'hac, 32'hcafef00d, 0, 2);

        // Wait states and timeout
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hdeadbeef);
        issue(0, 3'b010, 32'ha8, 32'h0, 3, 5);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(1, 0, 32'h0);
        issue(0, 3'b010, 32'ha8, 32'h0, 100, 5);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'h0000beef);
        issue(0, 3'b101, 32'ha8, 32'h0, 0, 2);

        // Reset while waiting on memory
        exp_mem(0, 4'h0, 32'ha8, 32'h0);
        cur_delay  = 100;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'ha8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_mem_valid", {68'd0, mem_valid}, 69'd0);
        check("abort_req_ready", {68'd0, req_ready}, 69'd1);
        check("abort_rdata", {37'd0, resp_rdata}, 69'd0);
        mem_exp_q.delete();
        repeat (3) @(posedge clk);
        #1;

        // Illegal funct3: no memory access
        exp_resp(1, 0, 32'h0);
        issue(0, 3'b011, 32'ha8, 32'h0, 0, 1);
        exp_resp(1, 0, 32'h0);
        issue(1, 3'b100, 32'ha8, 32'h77, 0, 1);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        exp_resp(0, 1, 32'h0);
        issue(0, 3'b010, 32'haa, 32'h0, 0, 1);
        exp_resp(0, 1, 32'h0);
        issue(1, 3'b001, 32'hab, 32'h1234, 0, 1);
        exp_resp(0, 1, 32'h0);
        issue(0, 3'b001, 32'hab, 32'h0, 0, 1);
`else
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hdeadbeef);
        issue(0, 3'b010, 32'haa, 32'h0, 0, 2);
        exp_mem(1, 4'b1100, 32'ha8, 32'h12340000); exp_resp(0, 0, 32'hdeadbeef);
        issue(1, 3'b001, 32'hab, 32'h1234, 0, 2);
        exp_mem(0, 4'h0, 32'ha8, 32'h0); exp_resp(0, 0, 32'hffffdead);
        issue(0, 3'b001, 32'hab, 32'h0, 0, 2);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("resp_queue_drained", 69'(exp_q.size()), 69'd0);
        check("mem_queue_drained", 69'(mem_exp_q.size()), 69'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
